// File: rtl/buffered_xy_switch.sv
// Input-buffered XY mesh router: three input FIFOs feed three registered outputs
// through per-output round-robin arbiters; illegal destinations are dropped and flagged.
module buffered_xy_switch #(
    parameter int x_coord     = 1,
    parameter int y_coord     = 1,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int data_width  = 8,
    parameter int total_width = 2*x_size + 2*y_size + data_width,
    parameter int fifo_depth  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid_l,
    input  logic                   i_valid_b,
    input  logic                   i_valid_pe,
    input  logic [total_width-1:0] i_data_l,
    input  logic [total_width-1:0] i_data_b,
    input  logic [total_width-1:0] i_data_pe,
    output logic                   o_ready_l,
    output logic                   o_ready_b,
    output logic                   o_ready_pe,
    output logic                   o_valid_r,
    output logic                   o_valid_t,
    output logic                   o_valid_pe,
    output logic [total_width-1:0] o_data_r,
    output logic [total_width-1:0] o_data_t,
    output logic [total_width-1:0] o_data_pe,
    input  logic                   i_ready_r,
    input  logic                   i_ready_t,
    input  logic                   i_ready_pe,
    output logic                   o_err,
    output logic [$clog2(fifo_depth):0] o_occ_l,
    output logic [$clog2(fifo_depth):0] o_occ_b,
    output logic [$clog2(fifo_depth):0] o_occ_pe
);
    localparam int PW = $clog2(fifo_depth);
    localparam int OW = PW + 1;
    localparam logic [x_size-1:0] XC = x_coord[x_size-1:0];
    localparam logic [y_size-1:0] YC = y_coord[y_size-1:0];
    localparam logic [1:0] RT_R = 2'd0, RT_T = 2'd1, RT_PE = 2'd2, RT_ILL = 2'd3;

    function automatic logic [1:0] route_of(input logic [total_width-1:0] d);
        logic [x_size-1:0] dx;
        logic [y_size-1:0] dy;
        dx = d[x_size+y_size-1:y_size];
        dy = d[y_size-1:0];
        if (dx > XC)                 return RT_R;
        if (dx == XC && dy > YC)     return RT_T;
        if (dx == XC && dy == YC)    return RT_PE;
        return RT_ILL;
    endfunction

    // Returns {found, index} of the first requester at or after p, wrapping mod 3.
    function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
        logic [2:0] res;
        logic [2:0] sum;
        logic [1:0] k;
        res = 3'b000;
        for (int j = 2; j >= 0; j--) begin
            sum = {1'b0, p} + 3'(j);
            k   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    logic [2:0]             in_vld, out_rdy, push, pop, nonempty, ill;
    logic [total_width-1:0] in_dat [3];
    logic [total_width-1:0] head [3];
    logic [total_width-1:0] mem [3][fifo_depth];
    logic [PW-1:0]          rd_ptr [3], wr_ptr [3];
    logic [OW-1:0]          occ [3];
    logic [1:0]             route [3];
    logic [2:0]             req [3];
    logic [2:0]             pick [3];
    logic [2:0]             free, gnt_v;
    logic [1:0]             gnt_idx [3];
    logic [1:0]             ptr_q [3];
    logic [2:0]             out_vld;
    logic [total_width-1:0] out_dat [3];
    logic                   err_q;

    assign in_vld    = {i_valid_pe, i_valid_b, i_valid_l};
    assign in_dat[0] = i_data_l;
    assign in_dat[1] = i_data_b;
    assign in_dat[2] = i_data_pe;
    assign out_rdy   = {i_ready_pe, i_ready_t, i_ready_r};

    always_comb begin
        push = '0;
        pop  = '0;
        ill  = '0;
        for (int i = 0; i < 3; i++) begin
            head[i]     = mem[i][rd_ptr[i]];
            nonempty[i] = (occ[i] != '0);
            route[i]    = route_of(head[i]);
            push[i]     = in_vld[i] && (occ[i] != OW'(fifo_depth));
            ill[i]      = nonempty[i] && (route[i] == RT_ILL);
        end
        for (int o = 0; o < 3; o++) begin
            req[o] = '0;
            for (int i = 0; i < 3; i++)
                req[o][i] = nonempty[i] && (route[i] == 2'(o));
            free[o]    = !out_vld[o] || out_rdy[o];
            pick[o]    = rr_pick(ptr_q[o], req[o]);
            gnt_v[o]   = free[o] && pick[o][2];
            gnt_idx[o] = pick[o][1:0];
        end
        pop = ill;
        for (int o = 0; o < 3; o++)
            if (gnt_v[o]) pop[gnt_idx[o]] = 1'b1;
    end

    // Input FIFO storage is data-only and never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= in_dat[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                occ[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])      occ[i] <= occ[i] + 1'b1;
                else if (!push[i] && pop[i]) occ[i] <= occ[i] - 1'b1;
            end
        end
    end

    // Output registers and arbiter pointers; a stalled output holds data and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < 3; o++) begin
                out_vld[o] <= 1'b0;
                out_dat[o] <= '0;
                ptr_q[o]   <= 2'd0;
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (gnt_v[o]) begin
                    out_vld[o] <= 1'b1;
                    out_dat[o] <= head[gnt_idx[o]];
                    ptr_q[o]   <= (gnt_idx[o] == 2'd2) ? 2'd0 : gnt_idx[o] + 2'd1;
                end else if (free[o]) begin
                    out_vld[o] <= 1'b0;
                end
            end
            if (|ill) err_q <= 1'b1;
        end
    end

    assign o_ready_l  = (occ[0] != OW'(fifo_depth));
    assign o_ready_b  = (occ[1] != OW'(fifo_depth));
    assign o_ready_pe = (occ[2] != OW'(fifo_depth));
    assign o_valid_r  = out_vld[0];
    assign o_valid_t  = out_vld[1];
    assign o_valid_pe = out_vld[2];
    assign o_data_r   = out_dat[0];
    assign o_data_t   = out_dat[1];
    assign o_data_pe  = out_dat[2];
    assign o_err      = err_q;
    assign o_occ_l    = occ[0];
    assign o_occ_b    = occ[1];
    assign o_occ_pe   = occ[2];
endmodule

// File: tb/tb_buffered_xy_switch.sv
// Bench for buffered_xy_switch: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_buffered_xy_switch;
    localparam int TW = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    vld = '0;
    logic [TW-1:0] dat [3];
    logic [2:0]    rdy = 3'b111;
    logic [2:0]    ordy, ov;
    logic [TW-1:0] od [3];
    logic [2:0]    occ [3];
    logic          err;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    // Reference model state: index 0/1/2 = l/b/pe for inputs, r/t/pe for outputs.
    logic [TW-1:0] mq [3][$];
    bit            mv [3];
    logic [TW-1:0] md [3];
    int            mp [3];
    bit            merr;

    buffered_xy_switch dut (
        .clk(clk), .rst(rst),
        .i_valid_l(vld[0]), .i_valid_b(vld[1]), .i_valid_pe(vld[2]),
        .i_data_l(dat[0]), .i_data_b(dat[1]), .i_data_pe(dat[2]),
        .o_ready_l(ordy[0]), .o_ready_b(ordy[1]), .o_ready_pe(ordy[2]),
        .o_valid_r(ov[0]), .o_valid_t(ov[1]), .o_valid_pe(ov[2]),
        .o_data_r(od[0]), .o_data_t(od[1]), .o_data_pe(od[2]),
        .i_ready_r(rdy[0]), .i_ready_t(rdy[1]), .i_ready_pe(rdy[2]),
        .o_err(err),
        .o_occ_l(occ[0]), .o_occ_b(occ[1]), .o_occ_pe(occ[2])
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Destination (1,1) is this switch; larger x goes right, same x larger y goes up.
    function automatic int route_of(input logic [TW-1:0] d);
        int dx, dy;
        dx = int'(d[3:2]);
        dy = int'(d[1:0]);
        if (dx > 1) return 0;
        if (dx == 1 && dy > 1) return 1;
        if (dx == 1 && dy == 1) return 2;
        return 3;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mv[i] = 1'b0;
            md[i] = '0;
            mp[i] = 0;
        end
        merr = 1'b0;
    endfunction

    function automatic void model_step();
        int sz [3];
        bit pushk [3];
        bit popk [3];
        for (int i = 0; i < 3; i++) begin
            sz[i]    = mq[i].size();
            pushk[i] = vld[i] && (sz[i] < DEPTH);
            popk[i]  = 1'b0;
        end
        for (int o = 0; o < 3; o++) begin
            if (!mv[o] || rdy[o]) begin
                int g;
                g = -1;
                for (int j = 0; j < 3; j++) begin
                    int k;
                    k = (mp[o] + j) % 3;
                    if (g < 0 && sz[k] > 0)
                        if (route_of(mq[k][0]) == o) g = k;
                end
                if (g >= 0) begin
                    mv[o] = 1'b1;
                    md[o] = mq[g][0];
                    popk[g] = 1'b1;
                    mp[o] = (g + 1) % 3;
                end else begin
                    mv[o] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 3; i++)
            if (sz[i] > 0)
                if (route_of(mq[i][0]) == 3) begin
                    popk[i] = 1'b1;
                    merr = 1'b1;
                end
        for (int i = 0; i < 3; i++) begin
            if (popk[i]) void'(mq[i].pop_front());
            if (pushk[i]) mq[i].push_back(dat[i]);
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int o = 0; o < 3; o++) begin
                check($sformatf("valid[%0d]", o), 32'(ov[o]), 32'(mv[o]));
                if (mv[o]) check($sformatf("data[%0d]", o), 32'(od[o]), 32'(md[o]));
                check($sformatf("occ[%0d]", o), 32'(occ[o]), 32'(mq[o].size()));
                check($sformatf("ready[%0d]", o), 32'(ordy[o]), 32'(mq[o].size() < DEPTH));
            end
            check("err", 32'(err), 32'(merr));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_step();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", 32'(ov[i]), 32'd0);
            check("rst_occ", 32'(occ[i]), 32'd0);
            check("rst_data", 32'(od[i]), 32'd0);
        end
        check("rst_err", 32'(err), 32'd0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) dat[i] = '0;
        model_reset();
        cycle();
        cycle();
        check("init_valid", 32'(ov), 32'd0);
        check("init_err", 32'(err), 32'd0);
        check("init_data_r", 32'(od[0]), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        cycle();
        check("init_ready", 32'(ordy), 32'h7);

        // Single packet left -> right
        vld[0] = 1'b1; dat[0] = 16'hA509;
        cycle();
        vld[0] = 1'b0;
        check("lat_early", 32'(ov[0]), 32'd0);
        cycle();
        check("lat_valid_r", 32'(ov[0]), 32'd1);
        check("lat_data_r", 32'(od[0]), 32'hA509);
        check("lat_other", 32'(ov[2:1]), 32'd0);
        check("lat_model", 32'(md[0]), 32'hA509);
        cycle();
        check("lat_gone", 32'(ov[0]), 32'd0);

        // Back-pressure fill on bottom -> top
        rdy[1] = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            vld[1] = 1'b1;
            dat[1] = {8'(n), 8'h06};
            cycle();
        end
        vld[1] = 1'b0;
        check("bp_occ", 32'(occ[1]), 32'd4);
        check("bp_ready", 32'(ordy[1]), 32'd0);
        check("bp_head", 32'(od[1]), 32'h0106);
        check("bp_valid", 32'(ov[1]), 32'd1);
        cycle();
        check("bp_hold", 32'(od[1]), 32'h0106);
        rdy[1] = 1'b1;
        for (int n = 2; n <= 5; n++) begin
            cycle();
            check("bp_drain", 32'(od[1]), 32'({8'(n), 8'h06}));
            if (n == 2) check("bp_ready_back", 32'(ordy[1]), 32'd1);
        end
        cycle();
        check("bp_empty", 32'(ov[1]), 32'd0);

        // Round-robin fairness into pe output
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b1;
            dat[i] = {8'(i), 8'h05};
        end
        cycle();
        for (int n = 0; n < 9; n++) begin
            cycle();
            check("rr_valid", 32'(ov[2]), 32'd1);
            check("rr_src", 32'(od[2][15:8]), 32'(n % 3));
        end
        vld = '0;
        for (int n = 0; n < 15; n++) cycle();

        // Illegal destination from pe
        vld[2] = 1'b1; dat[2] = 16'h3301;
        cycle();
        vld[2] = 1'b0;
        cycle();
        check("ill_err", 32'(err), 32'd1);
        check("ill_novalid", 32'(ov), 32'd0);
        cycle();
        check("ill_sticky", 32'(err), 32'd1);
        vld[2] = 1'b1; dat[2] = 16'h4409;
        cycle();
        vld[2] = 1'b0;
        cycle();
        check("ill_next_r", 32'(od[0]), 32'h4409);
        check("ill_next_v", 32'(ov[0]), 32'd1);

        // Concurrency: all three outputs in one cycle
        vld = 3'b111;
        dat[0] = 16'h1109; dat[1] = 16'h2207; dat[2] = 16'h3305;
        cycle();
        vld = '0;
        cycle();
        check("conc_valid", 32'(ov), 32'h7);
        check("conc_r", 32'(od[0]), 32'h1109);
        check("conc_t", 32'(od[1]), 32'h2207);
        check("conc_pe", 32'(od[2]), 32'h3305);

        // Reset while top is stalled with FIFOs partly full
        rdy[1] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            vld[0] = 1'b1; dat[0] = {8'(n), 8'h07};
            vld[1] = 1'b1; dat[1] = {8'(n + 8), 8'h06};
            cycle();
        end
        vld = '0;
        check("stall_valid_t", 32'(ov[1]), 32'd1);
        pulse_reset();
        rdy = 3'b111;
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("post_rst_valid", 32'(ov), 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                vld[i] = ($urandom_range(0, 99) < 60);
                dat[i] = TW'($urandom);
                rdy[i] = ($urandom_range(0, 99) < 75);
            end
            cycle();
        end
        vld = '0;
        rdy = 3'b111;
        for (int n = 0; n < 20; n++) cycle();

        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
